// File: rtl/s2p_load_sched_pkg.sv
// Purpose: shared types and constants for the seq2parallel load scheduler.
// Latency: n/a (types, constants and one elaboration-time helper only).
// Backpressure: n/a.
package s2p_load_sched_pkg;

    // Beats per row; matches the convolution kernel width.
    localparam int KERNEL_WIDTH = 3;

    // Ceiling log2, never less than 1, so that a counter always has at least one bit.
    function automatic int C_LOG_2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } main_state_t;

    typedef enum logic [1:0] {
        SL_EMPTY   = 2'd0,
        SL_LOADING = 2'd1,
        SL_STAGED  = 2'd2
    } slot_state_t;

    typedef enum logic {
        TGT_ACT = 1'b0,
        TGT_WGT = 1'b1
    } tgt_t;

endpackage

// File: rtl/s2p_slot_fsm.sv
// Purpose: tracks one loader's staging slot (EMPTY -> LOADING -> STAGED -> EMPTY).
// Latency: refresh is combinational on take while STAGED; empty/eligible are registered state.
// Backpressure: the slot holds STAGED while take=0, which blocks new grants for this target.
// Ports: req/grant/last_beat/take in; eligible_req, refresh, empty out.
module s2p_slot_fsm
    import s2p_load_sched_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req,
    input  logic grant,
    input  logic last_beat,
    input  logic take,
    output logic eligible_req,
    output logic refresh,
    output logic empty
);

    slot_state_t state;
    slot_state_t state_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SL_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SL_EMPTY:   if (grant)     state_nxt = SL_LOADING;
            SL_LOADING: if (last_beat) state_nxt = SL_STAGED;
            SL_STAGED:  if (take)      state_nxt = SL_EMPTY;
            default:                   state_nxt = SL_EMPTY;
        endcase
    end

    // Eligibility uses the registered state, so a slot refreshing this cycle
    // only becomes eligible on the next one.
    always_comb begin
        empty        = (state == SL_EMPTY);
        refresh      = (state == SL_STAGED) && take;
        eligible_req = req && (state == SL_EMPTY);
    end

endmodule

// File: rtl/s2p_load_sched.sv
// Purpose: shares one FWFT row source between the activation and weight seq2parallel loaders.
// Latency: begin/src_rd one cycle after the IDLE grant; NUM beats, one GAP, then IDLE again.
// Backpressure: grants wait for src_avail and an EMPTY slot; STAGED slots hold until take.
// Ports: act/wgt_req, act/wgt_take, src_avail in; src_rd, src_sel, *_begin, *_refresh, busy out.
module s2p_load_sched
    import s2p_load_sched_pkg::*;
#(
    parameter int NUM   = KERNEL_WIDTH,
    parameter int CNT_W = C_LOG_2(NUM)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic act_req,
    input  logic wgt_req,
    input  logic act_take,
    input  logic wgt_take,
    input  logic src_avail,
    output logic src_rd,
    output logic src_sel,
    output logic act_begin,
    output logic wgt_begin,
    output logic act_refresh,
    output logic wgt_refresh,
    output logic busy
);

    main_state_t       state;
    main_state_t       state_nxt;
    logic [CNT_W-1:0]  cnt;
    tgt_t              sel;
    tgt_t              ptr;
    tgt_t              pick;

    logic act_elig;
    logic wgt_elig;
    logic act_empty;
    logic wgt_empty;
    logic grant_go;
    logic grant_act;
    logic grant_wgt;
    logic last_beat;

    // Round-robin only matters when both sides are eligible.
    always_comb begin
        pick = TGT_ACT;
        if (act_elig && wgt_elig) begin
            pick = ptr;
        end else if (wgt_elig) begin
            pick = TGT_WGT;
        end
    end

    // src_avail is only looked at here: once granted, the burst runs to completion.
    assign grant_go  = (state == S_IDLE) && src_avail && (act_elig || wgt_elig);
    assign grant_act = grant_go && (pick == TGT_ACT);
    assign grant_wgt = grant_go && (pick == TGT_WGT);
    assign last_beat = (state == S_BURST) && (cnt == CNT_W'(NUM - 1));

    // State register together with the burst counter, target select and pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            sel   <= TGT_ACT;
            ptr   <= TGT_ACT;
        end else begin
            state <= state_nxt;
            if (grant_go) begin
                cnt <= '0;
                sel <= pick;
                ptr <= (pick == TGT_ACT) ? TGT_WGT : TGT_ACT;
            end else if (state == S_BURST) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_go)  state_nxt = S_BURST;
            S_BURST: if (last_beat) state_nxt = S_GAP;
            // One dead cycle so the loader's own beat counter wraps back to 0.
            S_GAP:                  state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // Outputs decode registered state only, so reset clears them immediately.
    always_comb begin
        src_rd    = (state == S_BURST);
        busy      = (state == S_BURST);
        src_sel   = sel;
        act_begin = (state == S_BURST) && (cnt == '0) && (sel == TGT_ACT);
        wgt_begin = (state == S_BURST) && (cnt == '0) && (sel == TGT_WGT);
    end

    s2p_slot_fsm u_act_slot (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (act_req),
        .grant        (grant_act),
        .last_beat    (last_beat && (sel == TGT_ACT)),
        .take         (act_take),
        .eligible_req (act_elig),
        .refresh      (act_refresh),
        .empty        (act_empty)
    );

    s2p_slot_fsm u_wgt_slot (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (wgt_req),
        .grant        (grant_wgt),
        .last_beat    (last_beat && (sel == TGT_WGT)),
        .take         (wgt_take),
        .eligible_req (wgt_elig),
        .refresh      (wgt_refresh),
        .empty        (wgt_empty)
    );

    // Slot emptiness is folded into eligibility; kept visible for debug probing.
    logic unused_empty;
    assign unused_empty = act_empty ^ wgt_empty;

endmodule
